// File: rtl/coil_guard.sv
// Stepper coil guard: forwards legal phase patterns to the coils,
// drops to PWM holding current when idle, de-energises on timeout or fault.
module coil_guard #(
    parameter logic [31:0] HOLD_CYCLES = 32'd500000,
    parameter logic [31:0] OFF_CYCLES  = 32'd25000000,
    parameter logic [7:0]  PWM_PERIOD  = 8'd100,
    parameter logic [7:0]  PWM_ON      = 8'd30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  step_in,
    input  logic        fault_clr,
    output logic [3:0]  coil_out,
    output logic        fault,
    output logic        hold,
    output logic [15:0] step_count
);

    typedef enum logic [1:0] {
        S_OFF,
        S_ACTIVE,
        S_HOLD,
        S_FAULT
    } state_t;

    localparam logic [31:0] HOLD_MAX = HOLD_CYCLES - 32'd1;
    localparam logic [31:0] IDLE_MAX = OFF_CYCLES - 32'd1;
    localparam logic [7:0]  PWM_LAST = PWM_PERIOD - 8'd1;

    state_t      state_q, state_d;
    logic [3:0]  step_q;
    logic [3:0]  coil_q, coil_d;
    logic [31:0] idle_q, idle_d;
    logic [7:0]  pwm_q, pwm_d;
    logic [15:0] cnt_q, cnt_d;

    logic        chg;
    logic        illegal;
    logic        accept;
    logic [31:0] idle_inc;
    logic [7:0]  pwm_inc;

    assign chg     = (step_in != step_q);
    // Opposite windings of either phase driven together would short the bridge
    assign illegal = (step_in[0] & step_in[2]) | (step_in[1] & step_in[3]);
    assign accept  = chg & ~illegal & (state_q != S_FAULT);

    // Idle counter saturates so a long-parked motor never wraps back to ACTIVE timing
    assign idle_inc = (idle_q == IDLE_MAX) ? idle_q : idle_q + 32'd1;
    assign pwm_inc  = (pwm_q >= PWM_LAST) ? 8'd0 : pwm_q + 8'd1;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_OFF;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decision; illegal input overrides every other event
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_OFF: begin
                if (illegal)  state_d = S_FAULT;
                else if (chg) state_d = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (illegal)
                    state_d = S_FAULT;
                else if (!chg && idle_q == HOLD_MAX)
                    state_d = S_HOLD;
            end
            S_HOLD: begin
                if (illegal)
                    state_d = S_FAULT;
                else if (chg)
                    state_d = S_ACTIVE;
                else if (idle_q == IDLE_MAX)
                    state_d = S_OFF;
            end
            S_FAULT: begin
                if (fault_clr && !illegal) state_d = S_OFF;
            end
            default: state_d = S_OFF;
        endcase
    end

    // Next coil drive and counter values for the chosen transition
    always_comb begin
        coil_d = 4'b0000;
        idle_d = idle_q;
        pwm_d  = pwm_q;
        cnt_d  = accept ? cnt_q + 16'd1 : cnt_q;
        unique case (state_q)
            S_OFF: begin
                if (!illegal && chg) begin
                    coil_d = step_in;
                    idle_d = 32'd0;
                    pwm_d  = 8'd0;
                end
            end
            S_ACTIVE: begin
                if (!illegal) begin
                    coil_d = step_in;
                    idle_d = chg ? 32'd0 : idle_inc;
                    if (state_d == S_HOLD) begin
                        pwm_d  = 8'd0;
                        coil_d = (PWM_ON != 8'd0) ? step_in : 4'b0000;
                    end
                end
            end
            S_HOLD: begin
                if (!illegal) begin
                    if (chg) begin
                        coil_d = step_in;
                        idle_d = 32'd0;
                        pwm_d  = 8'd0;
                    end else if (idle_q == IDLE_MAX) begin
                        idle_d = 32'd0;
                        pwm_d  = 8'd0;
                    end else begin
                        idle_d = idle_inc;
                        pwm_d  = pwm_inc;
                        coil_d = (pwm_inc < PWM_ON) ? step_q : 4'b0000;
                    end
                end
            end
            S_FAULT: begin
                if (state_d == S_OFF) begin
                    idle_d = 32'd0;
                    pwm_d  = 8'd0;
                end
            end
            default: begin
                idle_d = 32'd0;
                pwm_d  = 8'd0;
            end
        endcase
    end

    // Datapath registers; reset de-energises the coils without waiting for a clock
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_q <= 4'b0000;
            coil_q <= 4'b0000;
            idle_q <= 32'd0;
            pwm_q  <= 8'd0;
            cnt_q  <= 16'd0;
        end else begin
            step_q <= step_in;
            coil_q <= coil_d;
            idle_q <= idle_d;
            pwm_q  <= pwm_d;
            cnt_q  <= cnt_d;
        end
    end

    assign coil_out   = coil_q;
    assign fault      = (state_q == S_FAULT);
    assign hold       = (state_q == S_HOLD);
    assign step_count = cnt_q;

endmodule

// File: doc/coil_guard.md
COIL_GUARD -- requirements
Module: coil_guard

Interface
REQ-001 Parameter HOLD_CYCLES, default 32'd500000, idle cycles in ACTIVE before current reduction.
REQ-002 Parameter OFF_CYCLES, default 32'd25000000, idle cycles (counted from last step change) before coils de-energise.
REQ-003 Parameter PWM_PERIOD, default 8'd100, HOLD-state chopping period in clocks.
REQ-004 Parameter PWM_ON, default 8'd30, clocks per period the coils are driven in HOLD.
REQ-005 clk  input  1  system clock; all logic rising-edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 step_in  input  4  coil phase pattern from the stepper sequencer (StepDrive).
REQ-008 fault_clr  input  1  single-cycle pulse clearing a latched fault.
REQ-009 coil_out  output  4  registered coil drive to the motor driver board.
REQ-010 fault  output  1  high while in FAULT.
REQ-011 hold  output  1  high while in HOLD.
REQ-012 step_count  output  16  count of accepted step changes.

Function
REQ-013 step_q SHALL register step_in every cycle; chg = (step_in != step_q).
REQ-014 illegal = (step_in[0] & step_in[2]) | (step_in[1] & step_in[3]); 4'b0000 and all single/adjacent-pair patterns are legal.
REQ-015 State machine SHALL have states OFF, ACTIVE, HOLD, FAULT.
REQ-016 OFF: coil_out = 0; on legal chg -> ACTIVE, coil_out <= step_in, idle counter cleared.
REQ-017 ACTIVE: coil_out <= step_in each cycle (one-clock latency); idle counter clears on chg, else increments.
REQ-018 ACTIVE -> HOLD when idle counter reaches HOLD_CYCLES-1 with no chg that cycle.
REQ-019 HOLD: pwm counter runs 0..PWM_PERIOD-1 and wraps, starting at 0 on HOLD entry; coil_out = step_q while pwm < PWM_ON, else 0; hold = 1.
REQ-020 HOLD: idle counter keeps incrementing; on reaching OFF_CYCLES-1 -> OFF, coil_out = 0.
REQ-021 HOLD: legal chg -> ACTIVE next cycle, coil_out <= step_in, idle counter and pwm counter cleared.
REQ-022 In any state except FAULT, illegal step_in -> FAULT next cycle; coil_out = 0 that cycle, so an illegal pattern never appears on coil_out.
REQ-023 Illegal detection SHALL take priority over chg, timeout and PWM transitions in the same cycle.
REQ-024 FAULT: coil_out = 0, fault = 1, counters frozen; fault_clr -> OFF next cycle.
REQ-025 fault_clr coincident with illegal step_in SHALL leave the block in FAULT.
REQ-026 fault_clr outside FAULT SHALL have no effect.
REQ-027 step_count SHALL increment by 1 on each legal chg accepted in OFF, ACTIVE or HOLD, and wrap 16'hFFFF -> 0; no increment in FAULT or on illegal input.
REQ-028 Idle counter 32 bits, saturating at OFF_CYCLES-1; PWM_ON >= PWM_PERIOD means always on, and PWM_ON = 0 means always off in HOLD.
REQ-029 A transition to 4'b0000 in ACTIVE is a legal chg: coil_out = 0, idle counter cleared.

Reset
REQ-030 On rst high, immediately: state OFF, coil_out = 0, fault = 0, hold = 0, step_count = 0, step_q = 0, idle and pwm counters = 0.
REQ-031 Reset asserted mid-ACTIVE or mid-HOLD SHALL de-energise coils asynchronously; after release the block waits in OFF for a legal chg.

Verification
REQ-032 Reset, then step_in 0001 -> 0011 -> 0010, 4 cycles apart -> coil_out follows with one-clock latency, step_count = 3, fault = 0.
REQ-033 HOLD_CYCLES = 10, PWM_PERIOD = 4, PWM_ON = 1, OFF_CYCLES = 30, step_in held at 0110 -> hold rises after 10 idle cycles, coil_out toggles 0110/0000/0000/0000, and is 0 with hold = 0 after 30 idle cycles.
REQ-034 In HOLD, step_in 0110 -> 0100 -> ACTIVE next cycle, hold = 0, coil_out = 0100 steady, step_count + 1.
REQ-035 step_in = 0101 in ACTIVE -> coil_out = 0 next cycle, fault = 1, step_count unchanged; fault_clr with step_in = 0101 -> remains in FAULT; step_in = 0001 then fault_clr -> OFF, fault = 0.
REQ-036 Preload 65535 legal changes -> step_count wraps to 0 on the next change.
REQ-037 rst pulsed asynchronously between clock edges while coil_out = 1000 -> coil_out = 0 before the next edge, all outputs at reset values.
